// File: rtl/lfsr_prbs_sync_check_pkg.sv
// Purpose: shared types for the self-synchronising PRBS checker.
// Latency: n/a (types only).
// Backpressure: n/a.
package lfsr_prbs_sync_check_pkg;

  // Checker lock state.
  // SEED:   next valid word only seeds the predictor.
  // HUNT:   counting clean words towards lock.
  // LOCKED: counting errors and watching for loss of lock.
  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr_prbs_sync_check_lfsr.sv
// Purpose: combinational parallel LFSR step, DATA_WIDTH bits per call, Fibonacci or Galois form.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to use the result.
// Ports: data_in  - data XORed into the feedback, MSB first (tie to zero for a free-running PRBS)
//        state_in - current LFSR state
//        data_out - the DATA_WIDTH output bits produced from state_in
module lfsr_prbs_sync_check_lfsr #(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter string                 LFSR_CONFIG = "FIBONACCI",
  parameter bit                    REVERSE     = 1'b0,
  parameter int                    DATA_WIDTH  = 32,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

  if (!(LFSR_CONFIG == "FIBONACCI" || LFSR_CONFIG == "GALOIS")) begin : g_cfg_check
    $error("LFSR_CONFIG must be FIBONACCI or GALOIS");
  end

  // Both styles reduce to the same XOR network; the loop form is used for all of them.
  if (!(STYLE == "AUTO" || STYLE == "LOOP" || STYLE == "REDUCTION")) begin : g_style_check
    $error("STYLE must be AUTO, LOOP or REDUCTION");
  end

  logic [LFSR_WIDTH-1:0] s_in;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic [LFSR_WIDTH-1:0] s_work;
  logic                  fb_work;

  // REVERSE mirrors the bit order of every port.
  always_comb begin
    s_in = '0;
    d_in = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      s_in[i] = REVERSE ? state_in[LFSR_WIDTH-1-i] : state_in[i];
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      d_in[i] = REVERSE ? data_in[DATA_WIDTH-1-i] : data_in[i];
    end
  end

  // One LFSR shift per output bit; the first bit produced lands in the MSB.
  // Poly bit 0 is the implicit +1 term and is never a tap here.
  always_comb begin
    s_work  = s_in;
    fb_work = 1'b0;
    d_out   = '0;
    for (int k = DATA_WIDTH-1; k >= 0; k--) begin
      if (GALOIS) begin
        fb_work = s_work[LFSR_WIDTH-1] ^ d_in[k];
        s_work  = {s_work[LFSR_WIDTH-2:0], fb_work} ^
                  ({LFSR_POLY[LFSR_WIDTH-1:1], 1'b0} & {LFSR_WIDTH{fb_work}});
      end else begin
        fb_work = s_work[LFSR_WIDTH-1] ^ d_in[k] ^
                  (^(s_work[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
        s_work  = {s_work[LFSR_WIDTH-2:0], fb_work};
      end
      d_out[k] = fb_work;
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      data_out[i] = REVERSE ? d_out[DATA_WIDTH-1-i] : d_out[i];
    end
  end

endmodule

// File: rtl/lfsr_prbs_sync_check.sv
// Purpose: self-synchronising PRBS checker; seeds from received data, predicts the next word, tracks lock and errors.
// Latency: 2 cycles from data_valid to word_error / counter / locked update.
// Backpressure: none; every valid word is consumed, data_valid=0 simply holds all state.
// Ports: clk, rst_n (async active-low); data_in/data_valid - received word; cnt_clear - zero both counters;
//        locked - in LOCKED; word_error - per-word mismatch pulse; err_bit_count/err_word_count - saturating counters.
module lfsr_prbs_sync_check
  import lfsr_prbs_sync_check_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter bit                    REVERSE      = 1'b0,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    CNT_WIDTH    = 32,
  parameter string                 STYLE        = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  cnt_clear,
  output logic                  locked,
  output logic                  word_error,
  output logic [CNT_WIDTH-1:0]  err_bit_count,
  output logic [CNT_WIDTH-1:0]  err_word_count
);

  if (DATA_WIDTH < LFSR_WIDTH) begin : g_width_check
    $error("DATA_WIDTH must be >= LFSR_WIDTH");
  end

  localparam int PCW  = $clog2(DATA_WIDTH + 1);
  localparam int SUMW = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam int RUNW = $clog2(LOCK_COUNT + 1);
  localparam int BADW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [PCW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c + PCW'(v[i]);
    end
    return c;
  endfunction

  // ---------------- stage 1: predict, compare, reseed ----------------
  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] seed;
  logic [DATA_WIDTH-1:0] expected;
  logic [DATA_WIDTH-1:0] err_vec_q;
  logic                  err_vld_q;

  // The seed slice is the part of a word that equals the transmitter's state after producing it.
  if (REVERSE) begin : g_seed_rev
    assign seed = data_in[DATA_WIDTH-1 -: LFSR_WIDTH];
  end else begin : g_seed_fwd
    assign seed = data_in[LFSR_WIDTH-1:0];
  end

  lfsr_prbs_sync_check_lfsr #(
    .LFSR_WIDTH  (LFSR_WIDTH),
    .LFSR_POLY   (LFSR_POLY),
    .LFSR_CONFIG (LFSR_CONFIG),
    .REVERSE     (REVERSE),
    .DATA_WIDTH  (DATA_WIDTH),
    .STYLE       (STYLE)
  ) u_pred (
    .data_in  ('0),
    .state_in (state_q),
    .data_out (expected)
  );

  // Reloading from the received word every time makes the checker self-healing:
  // a corrupted seed only spoils the prediction of the following word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      err_vec_q <= '0;
      err_vld_q <= 1'b0;
    end else begin
      err_vld_q <= data_valid;
      if (data_valid) begin
        err_vec_q <= data_in ^ expected;
        state_q   <= seed;
      end
    end
  end

  // ---------------- stage 2: classify, count, lock FSM ----------------
  logic [PCW-1:0]       pop;
  logic                 word_err;
  logic [SUMW-1:0]      bit_sum;
  logic [CNT_WIDTH-1:0] bit_cnt_d;
  logic [CNT_WIDTH-1:0] word_cnt_d;
  logic [RUNW-1:0]      run_d;
  logic [BADW-1:0]      bad_d;

  chk_state_e           fsm_q;
  logic [RUNW-1:0]      run_q;
  logic [BADW-1:0]      bad_q;
  logic                 locked_q;
  logic                 word_error_q;
  logic [CNT_WIDTH-1:0] bit_cnt_q;
  logic [CNT_WIDTH-1:0] word_cnt_q;

  assign pop        = popcount(err_vec_q);
  assign word_err   = err_vld_q && (pop != '0);
  assign bit_sum    = SUMW'(bit_cnt_q) + SUMW'(pop);
  assign bit_cnt_d  = (bit_sum > SUMW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
  assign word_cnt_d = (word_cnt_q == CNT_MAX) ? CNT_MAX : word_cnt_q + CNT_WIDTH'(1);
  assign run_d      = run_q + RUNW'(1);
  assign bad_d      = bad_q + BADW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= SEED;
      run_q        <= '0;
      bad_q        <= '0;
      locked_q     <= 1'b0;
      word_error_q <= 1'b0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
    end else begin
      word_error_q <= 1'b0;
      if (err_vld_q) begin
        case (fsm_q)
          // The seed word was compared against a stale state; its result is meaningless.
          SEED: begin
            fsm_q <= HUNT;
            run_q <= '0;
          end
          HUNT: begin
            word_error_q <= word_err;
            if (word_err) begin
              run_q <= '0;
            end else if (run_d == RUNW'(LOCK_COUNT)) begin
              fsm_q    <= LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
              bad_q    <= '0;
            end else begin
              run_q <= run_d;
            end
          end
          LOCKED: begin
            word_error_q <= word_err;
            if (word_err) begin
              bit_cnt_q  <= bit_cnt_d;
              word_cnt_q <= word_cnt_d;
              if (bad_d == BADW'(UNLOCK_COUNT)) begin
                fsm_q    <= SEED;
                locked_q <= 1'b0;
                bad_q    <= '0;
              end else begin
                bad_q <= bad_d;
              end
            end else begin
              bad_q <= '0;
            end
          end
          default: begin
            fsm_q    <= SEED;
            locked_q <= 1'b0;
          end
        endcase
      end
      // Last assignment wins, so a clear overrides an increment in the same cycle.
      if (cnt_clear) begin
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end
    end
  end

  assign locked         = locked_q;
  assign word_error     = word_error_q;
  assign err_bit_count  = bit_cnt_q;
  assign err_word_count = word_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_sync_check.sv
// Purpose: directed bench for lfsr_prbs_sync_check with a PRBS31 source (x^31 + x^28 + 1, 32-bit words).
// Latency: checks the 2-cycle word -> status latency at lock, unlock and error points.
// Backpressure: exercises data_valid gaps; the DUT has no ready.
module tb_lfsr_prbs_sync_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_valid;
  logic        cnt_clear;
  logic        locked;
  logic        word_error;
  logic [3:0]  err_bit_count;
  logic [3:0]  err_word_count;

  int          total;
  int          bad;
  int          pulses;
  int          nvalid;
  logic [30:0] g;

  always #5 clk = ~clk;

  lfsr_prbs_sync_check #(
    .CNT_WIDTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .cnt_clear      (cnt_clear),
    .locked         (locked),
    .word_error     (word_error),
    .err_bit_count  (err_bit_count),
    .err_word_count (err_word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference PRBS31 transmitter: feedback s[30]^s[27], first bit out is the word MSB.
  task automatic gen(output logic [31:0] o);
    logic fb;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      fb = g[30] ^ g[27];
      g  = {g[29:0], fb};
      o  = {o[30:0], fb};
    end
  endtask

  // Apply inputs, take one clock, sample 1 ns after the edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic clr);
    data_valid = v;
    data_in    = d;
    cnt_clear  = clr;
    @(posedge clk);
    #1;
    if (word_error) pulses++;
  endtask

  task automatic send(input logic [31:0] flip, input logic clr);
    logic [31:0] w;
    gen(w);
    drive(1'b1, w ^ flip, clr);
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0; nvalid = 0;
    g = '1;
    rst_n = 1'b0; data_valid = 1'b0; data_in = '0; cnt_clear = 1'b0;

    // ---- reset values ----
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_word_error", word_error, 0);
    chk("rst_bits", err_bit_count, 0);
    chk("rst_words", err_word_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- clean lock: seed + 16 clean words, visible one word later ----
    for (int k = 1; k <= 17; k++) send(32'h0, 1'b0);
    chk("lock_not_yet", locked, 0);
    send(32'h0, 1'b0);
    chk("lock_after_17", locked, 1);
    for (int k = 0; k < 982; k++) send(32'h0, 1'b0);
    chk("clean_pulses", pulses, 0);
    chk("clean_bits", err_bit_count, 0);
    chk("clean_words", err_word_count, 0);

    // ---- single bit error: corrupted word plus the word predicted from it ----
    pulses = 0;
    send(32'h1, 1'b0);
    send(32'h0, 1'b0);
    chk("sbe_pulse1", word_error, 1);
    send(32'h0, 1'b0);
    chk("sbe_pulse2", word_error, 1);
    send(32'h0, 1'b0);
    chk("sbe_quiet", word_error, 0);
    chk("sbe_pulses", pulses, 2);
    chk("sbe_words", err_word_count, 2);
    chk("sbe_bits", err_bit_count, 3);
    chk("sbe_locked", locked, 1);
    send(32'h0, 1'b1);
    chk("clr_bits", err_bit_count, 0);
    chk("clr_words", err_word_count, 0);

    // ---- loss of lock: 4 inverted words ----
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    chk("lol_still_locked", locked, 1);
    chk("lol_words3", err_word_count, 3);
    chk("lol_bits_sat", err_bit_count, 15);
    send(32'h0, 1'b1);                    // 4th errored word reaches stage 2 together with a clear
    chk("lol_unlocked", locked, 0);
    chk("lol_clr_bits", err_bit_count, 0);
    chk("lol_clr_words", err_word_count, 0);
    send(32'h0, 1'b0);
    chk("reseed_no_pulse", word_error, 0);

    // ---- relock with an error during HUNT (restarts the run, not counted) ----
    for (int k = 0; k < 3; k++) send(32'h0, 1'b0);
    send(32'h1, 1'b0);
    send(32'h0, 1'b0);
    chk("hunt_pulse", word_error, 1);
    for (int k = 0; k < 16; k++) send(32'h0, 1'b0);
    chk("hunt_no_bits", err_bit_count, 0);
    chk("hunt_no_words", err_word_count, 0);
    chk("relock_not_yet", locked, 0);
    send(32'h0, 1'b0);
    chk("relock", locked, 1);

    // ---- saturation: 20 single-bit hits, each 2 errored words / 3 bits ----
    for (int k = 1; k <= 20; k++) begin
      send(32'h1, 1'b0);
      send(32'h0, 1'b0);
      send(32'h0, 1'b0);
      send(32'h0, 1'b0);
      if (k == 7) chk("sat_words_14", err_word_count, 14);
      if (k == 8) chk("sat_words_15", err_word_count, 15);
    end
    chk("sat_words_end", err_word_count, 15);
    chk("sat_bits_end", err_bit_count, 15);
    chk("sat_locked", locked, 1);

    // ---- clear coincident with errored words ----
    send(32'h1, 1'b0);
    send(32'h0, 1'b1);
    send(32'h0, 1'b1);
    chk("clr_err_bits", err_bit_count, 0);
    chk("clr_err_words", err_word_count, 0);
    send(32'h0, 1'b0);
    chk("clr_err_hold", err_word_count, 0);

    // ---- async reset between edges ----
    send(32'h1, 1'b0);
    send(32'h0, 1'b0);
    send(32'h0, 1'b0);
    chk("pre_rst_words", err_word_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_bits", err_bit_count, 0);
    chk("arst_words", err_word_count, 0);
    #2 rst_n = 1'b1;

    // ---- gaps: random 50% valid, lock after 17 valid words ----
    pulses = 0;
    while (nvalid < 17) begin
      if ($urandom_range(0, 1) == 1) begin
        send(32'h0, 1'b0);
        nvalid++;
      end else begin
        drive(1'b0, $urandom, 1'b0);
      end
    end
    chk("gap_lock_not_yet", locked, 0);
    drive(1'b0, $urandom, 1'b0);
    chk("gap_lock", locked, 1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1) send(32'h0, 1'b0);
      else drive(1'b0, $urandom, 1'b0);
    end
    chk("gap_pulses", pulses, 0);
    chk("gap_bits", err_bit_count, 0);
    chk("gap_words", err_word_count, 0);
    chk("gap_locked", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
